// File: rtl/dbus_timer_pkg.sv
// Shared DBus peripheral definitions: bus widths, register map, CTRL/STATUS
// bit positions and the zero-when-unselected read-data rule.
package dbus_timer_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned ADDR_W     = 30;
    localparam int unsigned BE_W       = 4;
    localparam int unsigned PRESCALE_W = 8;

    localparam logic [1:0] OFF_CTRL    = 2'd0;
    localparam logic [1:0] OFF_COUNT   = 2'd1;
    localparam logic [1:0] OFF_COMPARE = 2'd2;
    localparam logic [1:0] OFF_STATUS  = 2'd3;

    localparam int unsigned CTRL_EN_BIT       = 0;
    localparam int unsigned CTRL_IRQ_EN_BIT   = 1;
    localparam int unsigned CTRL_RELOAD_BIT   = 2;
    localparam int unsigned CTRL_PRESCALE_LSB = 8;
    localparam int unsigned STATUS_MATCH_BIT  = 0;

    // Implemented CTRL bits; everything else reads 0 and ignores writes.
    localparam logic [DATA_W-1:0] CTRL_MASK = 32'h0000_FF07;

    // Slaves return zero when not addressed so read buses can be OR-combined.
    function automatic logic [DATA_W-1:0] read_gate(input logic hit,
                                                    input logic [DATA_W-1:0] data);
        return hit ? data : '0;
    endfunction

endpackage

// File: rtl/dbus_timer_prescaler.sv
// 8-bit prescaler: emits a one-cycle tick every PRESCALE+1 enabled cycles.
module dbus_timer_prescaler
    import dbus_timer_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  clear,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  tick_c
);

    logic [PRESCALE_W-1:0] pc_q;
    logic [PRESCALE_W-1:0] pc_d;

    always_comb begin
        tick_c = 1'b0;
        pc_d   = pc_q;
        if (!en || clear) begin
            pc_d = '0;
        end else if (pc_q == prescale) begin
            tick_c = 1'b1;
            pc_d   = '0;
        end else begin
            pc_d = pc_q + PRESCALE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: rtl/dbus_timer.sv
// DBus timer/compare slave: CTRL, COUNT, COMPARE, STATUS with one-cycle
// registered read data and a registered level interrupt.
module dbus_timer
    import dbus_timer_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE_ADDR = 30'h0000_0400
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] dbus_address,
    input  logic [BE_W-1:0]   dbus_byte_en,
    input  logic              dbus_read,
    input  logic              dbus_write,
    input  logic [DATA_W-1:0] dbus_write_data,
    output logic [DATA_W-1:0] dbus_read_data,
    output logic              irq
);

    logic [DATA_W-1:0] ctrl_q, ctrl_d;
    logic [DATA_W-1:0] count_q, count_d;
    logic [DATA_W-1:0] compare_q, compare_d;
    logic              match_q, match_d;
    logic              irq_d;
    logic [DATA_W-1:0] read_data_d;
    logic [DATA_W-1:0] count_inc;
    logic [DATA_W-1:0] reg_value;
    logic [1:0]        offset;
    logic              sel;
    logic              wr_any;
    logic              ctrl_wr;
    logic              tick;
    logic              match_hit;

    function automatic logic [DATA_W-1:0] merge_lanes(input logic [DATA_W-1:0] cur,
                                                      input logic [DATA_W-1:0] wdata,
                                                      input logic [BE_W-1:0]   be);
        logic [DATA_W-1:0] r;
        r = cur;
        for (int k = 0; k < int'(BE_W); k++) begin
            if (be[k]) begin
                r[8*k +: 8] = wdata[8*k +: 8];
            end
        end
        return r;
    endfunction

    assign sel     = (dbus_address[ADDR_W-1:2] == BASE_ADDR[ADDR_W-1:2]);
    assign offset  = dbus_address[1:0];
    assign wr_any  = sel && dbus_write && (|dbus_byte_en);
    assign ctrl_wr = wr_any && (offset == OFF_CTRL);

    dbus_timer_prescaler u_prescaler (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (ctrl_q[CTRL_EN_BIT]),
        .clear    (ctrl_wr),
        .prescale (ctrl_q[CTRL_PRESCALE_LSB +: PRESCALE_W]),
        .tick_c   (tick)
    );

    // Next-state for registers; bus writes override the counter per lane.
    always_comb begin
        ctrl_d    = ctrl_q;
        compare_d = compare_q;
        match_d   = match_q;
        match_hit = tick && (count_q == compare_q);
        count_inc = count_q;
        reg_value = '0;

        if (tick) begin
            count_inc = (match_hit && ctrl_q[CTRL_RELOAD_BIT]) ? '0 : count_q + DATA_W'(1);
        end
        count_d = count_inc;

        if (wr_any) begin
            case (offset)
                OFF_CTRL:    ctrl_d    = merge_lanes(ctrl_q, dbus_write_data, dbus_byte_en) & CTRL_MASK;
                OFF_COUNT:   count_d   = merge_lanes(count_inc, dbus_write_data, dbus_byte_en);
                OFF_COMPARE: compare_d = merge_lanes(compare_q, dbus_write_data, dbus_byte_en);
                default: begin
                    if (dbus_byte_en[0] && dbus_write_data[STATUS_MATCH_BIT]) begin
                        match_d = 1'b0;
                    end
                end
            endcase
        end
        if (match_hit) begin
            match_d = 1'b1;
        end

        irq_d = match_d && ctrl_d[CTRL_IRQ_EN_BIT];

        case (offset)
            OFF_CTRL:    reg_value = ctrl_q;
            OFF_COUNT:   reg_value = count_q;
            OFF_COMPARE: reg_value = compare_q;
            OFF_STATUS:  reg_value = DATA_W'(match_q) << STATUS_MATCH_BIT;
            default:     reg_value = '0;
        endcase
        read_data_d = read_gate(sel && dbus_read, reg_value);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q         <= '0;
            count_q        <= '0;
            compare_q      <= '0;
            match_q        <= 1'b0;
            irq            <= 1'b0;
            dbus_read_data <= '0;
        end else begin
            ctrl_q         <= ctrl_d;
            count_q        <= count_d;
            compare_q      <= compare_d;
            match_q        <= match_d;
            irq            <= irq_d;
            dbus_read_data <= read_data_d;
        end
    end

endmodule

// File: tb/tb_dbus_timer.sv
// Directed bench for dbus_timer with hand-computed expectations.
module tb_dbus_timer;

    localparam logic [29:0] BASE = 30'h0000_0400;
    localparam logic [1:0]  R_CTRL = 2'd0, R_COUNT = 2'd1, R_COMPARE = 2'd2, R_STATUS = 2'd3;

    logic        clk;
    logic        rst_n;
    logic [29:0] dbus_address;
    logic [3:0]  dbus_byte_en;
    logic        dbus_read;
    logic        dbus_write;
    logic [31:0] dbus_write_data;
    logic [31:0] dbus_read_data;
    logic        irq;

    int n_cmp  = 0;
    int n_fail = 0;

    dbus_timer #(.BASE_ADDR(BASE)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .dbus_address    (dbus_address),
        .dbus_byte_en    (dbus_byte_en),
        .dbus_read       (dbus_read),
        .dbus_write      (dbus_write),
        .dbus_write_data (dbus_write_data),
        .dbus_read_data  (dbus_read_data),
        .irq             (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [29:0] reg_addr(input logic [1:0] off);
        return BASE | {28'd0, off};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Each access occupies exactly one cycle: called and returns at a negedge.
    task automatic bus_read(input logic [29:0] addr, output logic [31:0] data);
        dbus_address = addr;
        dbus_read    = 1'b1;
        @(posedge clk);
        #1 data = dbus_read_data;
        @(negedge clk);
        dbus_read = 1'b0;
    endtask

    task automatic bus_write(input logic [1:0] off, input logic [31:0] d, input logic [3:0] be);
        dbus_address    = reg_addr(off);
        dbus_write      = 1'b1;
        dbus_byte_en    = be;
        dbus_write_data = d;
        @(posedge clk);
        @(negedge clk);
        dbus_write   = 1'b0;
        dbus_byte_en = 4'b0000;
    endtask

    task automatic rd_chk(input string tag, input logic [1:0] off, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(reg_addr(off), d);
        chk(tag, d, exp);
    endtask

    initial begin
        logic [31:0] d;
        rst_n = 1'b0;
        dbus_address = '0;
        dbus_byte_en = '0;
        dbus_read = 1'b0;
        dbus_write = 1'b0;
        dbus_write_data = '0;
        #1;
        chk("rst_rdata", dbus_read_data, 32'h0);
        chk("rst_irq", {31'd0, irq}, 32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        rd_chk("rst_ctrl", R_CTRL, 32'h0);
        rd_chk("rst_count", R_COUNT, 32'h0);
        rd_chk("rst_compare", R_COMPARE, 32'h0);
        rd_chk("rst_status", R_STATUS, 32'h0);
        bus_read(BASE + 30'd4, d);
        chk("unsel_read", d, 32'h0);

        // Auto-reload at COMPARE=5, prescale 0.
        bus_write(R_COMPARE, 32'd5, 4'hF);
        bus_write(R_CTRL, 32'h0000_0007, 4'hF);
        for (int i = 0; i < 8; i++) begin
            bus_read(reg_addr(R_COUNT), d);
            chk($sformatf("reload_cnt%0d", i), d, (i <= 5) ? 32'(i) : 32'(i - 6));
            chk($sformatf("reload_irq%0d", i), {31'd0, irq}, (i >= 5) ? 32'd1 : 32'd0);
        end
        rd_chk("match_status", R_STATUS, 32'h1);
        bus_write(R_STATUS, 32'h1, 4'h1);
        chk("w1c_irq", {31'd0, irq}, 32'h0);
        bus_write(R_CTRL, 32'h0, 4'hF);

        // Prescale 3: one tick per 4 cycles, then wrap without match.
        bus_write(R_COUNT, 32'h0, 4'hF);
        bus_write(R_COMPARE, 32'd7, 4'hF);
        bus_write(R_CTRL, 32'h0000_0301, 4'hF);
        for (int i = 0; i < 8; i++) begin
            bus_read(reg_addr(R_COUNT), d);
            chk($sformatf("presc_cnt%0d", i), d, 32'(i / 4));
        end
        bus_write(R_COUNT, 32'hFFFF_FFFF, 4'hF);
        for (int i = 0; i < 4; i++) begin
            bus_read(reg_addr(R_COUNT), d);
            chk($sformatf("wrap_cnt%0d", i), d, (i < 3) ? 32'hFFFF_FFFF : 32'h0);
        end
        rd_chk("wrap_nomatch", R_STATUS, 32'h0);

        // Byte-lane writes with the counter stopped.
        bus_write(R_CTRL, 32'h0, 4'hF);
        bus_write(R_COUNT, 32'h1234_5678, 4'hF);
        bus_write(R_COUNT, 32'h0000_AB00, 4'b0010);
        rd_chk("lane_write", R_COUNT, 32'h1234_AB78);
        bus_write(R_COUNT, 32'hFFFF_FFFF, 4'b0000);
        rd_chk("be0_noop", R_COUNT, 32'h1234_AB78);
        bus_write(R_CTRL, 32'hFFFF_FF00, 4'hF);
        rd_chk("ctrl_mask", R_CTRL, 32'h0000_FF00);

        // Bus/tick collisions: set beats W1C, written lanes beat increment.
        bus_write(R_COUNT, 32'h50, 4'hF);
        bus_write(R_COMPARE, 32'h52, 4'hF);
        bus_write(R_CTRL, 32'h0000_0003, 4'hF);
        rd_chk("coll_cnt0", R_COUNT, 32'h50);
        rd_chk("coll_cnt1", R_COUNT, 32'h51);
        bus_write(R_STATUS, 32'h1, 4'h1);
        chk("set_beats_w1c", {31'd0, irq}, 32'h1);
        bus_write(R_COUNT, 32'h100, 4'hF);
        rd_chk("tick_write", R_COUNT, 32'h100);
        rd_chk("coll_status", R_STATUS, 32'h1);
        bus_write(R_COUNT, 32'h0000_00AA, 4'b0001);
        rd_chk("tick_lane", R_COUNT, 32'h0000_01AA);

        // Asynchronous reset mid-read with MATCH and irq high.
        dbus_address = reg_addr(R_COUNT);
        dbus_read = 1'b1;
        @(posedge clk);
        #1 chk("pre_rst_read", dbus_read_data, 32'h0000_01AB);
        chk("pre_rst_irq", {31'd0, irq}, 32'h1);
        #2 rst_n = 1'b0;
        #1 chk("async_rdata", dbus_read_data, 32'h0);
        chk("async_irq", {31'd0, irq}, 32'h0);
        dbus_read = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rd_chk("post_ctrl", R_CTRL, 32'h0);
        rd_chk("post_count", R_COUNT, 32'h0);
        rd_chk("post_compare", R_COMPARE, 32'h0);
        rd_chk("post_status", R_STATUS, 32'h0);
        rd_chk("post_idle", R_COUNT, 32'h0);
        bus_write(R_CTRL, 32'h0000_0001, 4'hF);
        rd_chk("resume_cnt0", R_COUNT, 32'h0);
        rd_chk("resume_cnt1", R_COUNT, 32'h1);
        rd_chk("resume_match", R_STATUS, 32'h1);
        chk("resume_irq_off", {31'd0, irq}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
